// File: rtl/iterative_alu_wb.sv
// Execute/writeback stage: takes register-file operands, runs one ALU op
// (single-cycle, shift-add MUL, or bit-serial shift) and issues one write.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands captured on the accept edge
// S_ITER | multi-cycle op in progress, one MUL step or shift per edge
// S_WB   | result presented on the write port for exactly one cycle
module iterative_alu_wb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [4:0]       dst,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_WB} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [4:0]       dst_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic [SW-1:0]    shamt;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;

  assign accept  = (state == S_IDLE) && start;
  assign shamt   = src_b[SW-1:0];
  assign slt_bit = $signed(src_a) < $signed(src_b);

  // Value loaded into the result register at accept; shifts seed with src_a,
  // MUL seeds the accumulator with zero.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:         alu_res = src_a + src_b;
      OP_SUB:         alu_res = src_a - src_b;
      OP_AND:         alu_res = src_a & src_b;
      OP_OR:          alu_res = src_a | src_b;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL, OP_SRL: alu_res = src_a;
      default:        alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; shifts by zero skip ITER entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL)                                  state_nxt = S_ITER;
          else if ((op == OP_SLL || op == OP_SRL) && shamt != '0) state_nxt = S_ITER;
          else                                               state_nxt = S_WB;
        end
      end
      S_ITER:  if (cnt_q == CW'(1)) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and iterative datapath (shift-add multiply, 1-bit shifts).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      dst_q    <= '0;
      res_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q     <= op;
      dst_q    <= dst;
      res_q    <= alu_res;
      mcand_q  <= src_a;
      mplier_q <= src_b;
      cnt_q    <= (op == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt};
    end else if (state == S_ITER) begin
      cnt_q <= cnt_q - CW'(1);
      case (op_q)
        OP_MUL: begin
          if (mplier_q[0]) res_q <= res_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
        OP_SLL:  res_q <= res_q << 1;
        OP_SRL:  res_q <= res_q >> 1;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_WB);
  assign we3  = done && (dst_q != 5'd0);
  assign wa3  = dst_q;
  assign wd3  = res_q;

endmodule
